// File: rtl/box_overlay.sv
// Multi-rectangle video overlay with a double-buffered box bank and a fixed two-cycle pipeline.
// Lowest box index wins where boxes overlap; vde low forces black.
module box_overlay #(
  parameter int unsigned NUM_BOXES = 4,
  parameter int unsigned COORD_W   = 10,
  parameter int unsigned COLOR_W   = 8,
  localparam int unsigned IDX_W    = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic                 cfg_en,
  input  logic                 cfg_outline,
  input  logic [COORD_W-1:0]   cfg_x0,
  input  logic [COORD_W-1:0]   cfg_x1,
  input  logic [COORD_W-1:0]   cfg_y0,
  input  logic [COORD_W-1:0]   cfg_y1,
  input  logic [3*COLOR_W-1:0] cfg_color,
  input  logic                 frame_start,
  input  logic [COORD_W-1:0]   x,
  input  logic [COORD_W-1:0]   y,
  input  logic                 vde,
  input  logic                 hsync,
  input  logic                 vsync,
  input  logic [COLOR_W-1:0]   base_red,
  input  logic [COLOR_W-1:0]   base_green,
  input  logic [COLOR_W-1:0]   base_blue,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 vde_o,
  output logic                 hsync_o,
  output logic                 vsync_o
);

  localparam int unsigned PIX_W = 3 * COLOR_W;

  logic [NUM_BOXES-1:0] sh_en, sh_ol, act_en, act_ol;
  logic [COORD_W-1:0]   sh_x0  [NUM_BOXES];
  logic [COORD_W-1:0]   sh_x1  [NUM_BOXES];
  logic [COORD_W-1:0]   sh_y0  [NUM_BOXES];
  logic [COORD_W-1:0]   sh_y1  [NUM_BOXES];
  logic [PIX_W-1:0]     sh_col [NUM_BOXES];
  logic [COORD_W-1:0]   act_x0  [NUM_BOXES];
  logic [COORD_W-1:0]   act_x1  [NUM_BOXES];
  logic [COORD_W-1:0]   act_y0  [NUM_BOXES];
  logic [COORD_W-1:0]   act_y1  [NUM_BOXES];
  logic [PIX_W-1:0]     act_col [NUM_BOXES];

  logic                 wr_ok;
  assign wr_ok = cfg_we && (32'(cfg_idx) < 32'(NUM_BOXES));

  // The swap reads shadow before this edge's write lands, so a same-cycle write waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_en  <= '0;
      sh_ol  <= '0;
      act_en <= '0;
      act_ol <= '0;
      for (int i = 0; i < int'(NUM_BOXES); i++) begin
        sh_x0[i]   <= '0;
        sh_x1[i]   <= '0;
        sh_y0[i]   <= '0;
        sh_y1[i]   <= '0;
        sh_col[i]  <= '0;
        act_x0[i]  <= '0;
        act_x1[i]  <= '0;
        act_y0[i]  <= '0;
        act_y1[i]  <= '0;
        act_col[i] <= '0;
      end
    end else begin
      if (wr_ok) begin
        sh_en[cfg_idx]  <= cfg_en;
        sh_ol[cfg_idx]  <= cfg_outline;
        sh_x0[cfg_idx]  <= cfg_x0;
        sh_x1[cfg_idx]  <= cfg_x1;
        sh_y0[cfg_idx]  <= cfg_y0;
        sh_y1[cfg_idx]  <= cfg_y1;
        sh_col[cfg_idx] <= cfg_color;
      end
      if (frame_start) begin
        act_en  <= sh_en;
        act_ol  <= sh_ol;
        act_x0  <= sh_x0;
        act_x1  <= sh_x1;
        act_y0  <= sh_y0;
        act_y1  <= sh_y1;
        act_col <= sh_col;
      end
    end
  end

  logic [NUM_BOXES-1:0] hit;

  always_comb begin
    hit = '0;
    for (int i = 0; i < int'(NUM_BOXES); i++) begin
      hit[i] = act_en[i]
            && (x >= act_x0[i]) && (x <= act_x1[i])
            && (y >= act_y0[i]) && (y <= act_y1[i])
            && (!act_ol[i] || (x == act_x0[i]) || (x == act_x1[i])
                           || (y == act_y0[i]) || (y == act_y1[i]));
    end
  end

  // Colours travel with the hit vector so a bank swap cannot recolour in-flight pixels.
  logic [NUM_BOXES-1:0] s1_hit;
  logic [PIX_W-1:0]     s1_col [NUM_BOXES];
  logic [PIX_W-1:0]     s1_base;
  logic                 s1_vde, s1_hs, s1_vs;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_hit  <= '0;
      s1_base <= '0;
      s1_vde  <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      for (int i = 0; i < int'(NUM_BOXES); i++) begin
        s1_col[i] <= '0;
      end
    end else begin
      s1_hit  <= hit;
      s1_col  <= act_col;
      s1_base <= {base_red, base_green, base_blue};
      s1_vde  <= vde;
      s1_hs   <= hsync;
      s1_vs   <= vsync;
    end
  end

  logic [PIX_W-1:0] sel_col;

  always_comb begin
    sel_col = s1_base;
    for (int i = int'(NUM_BOXES) - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        sel_col = s1_col[i];
      end
    end
    if (!s1_vde) begin
      sel_col = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      red     <= '0;
      green   <= '0;
      blue    <= '0;
      vde_o   <= 1'b0;
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
    end else begin
      {red, green, blue} <= sel_col;
      vde_o   <= s1_vde;
      hsync_o <= s1_hs;
      vsync_o <= s1_vs;
    end
  end

endmodule

// File: tb/tb_box_overlay.sv
// Directed self-checking bench for box_overlay: passthrough latency, fill/outline, priority,
// double-buffer timing, inverted boxes, vde blanking and mid-line reset.
module tb_box_overlay;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic        cfg_en, cfg_outline;
  logic [9:0]  cfg_x0, cfg_x1, cfg_y0, cfg_y1;
  logic [23:0] cfg_color;
  logic        frame_start;
  logic [9:0]  x, y;
  logic        vde, hsync, vsync;
  logic [7:0]  base_red, base_green, base_blue;
  logic [7:0]  red, green, blue;
  logic        vde_o, hsync_o, vsync_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  box_overlay dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_outline(cfg_outline),
    .cfg_x0(cfg_x0), .cfg_x1(cfg_x1), .cfg_y0(cfg_y0), .cfg_y1(cfg_y1),
    .cfg_color(cfg_color), .frame_start(frame_start),
    .x(x), .y(y), .vde(vde), .hsync(hsync), .vsync(vsync),
    .base_red(base_red), .base_green(base_green), .base_blue(base_blue),
    .red(red), .green(green), .blue(blue),
    .vde_o(vde_o), .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  function automatic logic [23:0] base_of(input int xx, input int yy);
    return {8'(xx), 8'(yy), 8'h5A};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int idx, input logic en, input logic ol, input int x0, input int y0,
                     input int x1, input int y1, input logic [23:0] col, input logic fs);
    cfg_we      = 1'b1;
    cfg_idx     = 2'(idx);
    cfg_en      = en;
    cfg_outline = ol;
    cfg_x0      = 10'(x0);
    cfg_y0      = 10'(y0);
    cfg_x1      = 10'(x1);
    cfg_y1      = 10'(y1);
    cfg_color   = col;
    frame_start = fs;
    tick();
    cfg_we      = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic swap();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic drive(input int xx, input int yy, input logic v);
    x     = 10'(xx);
    y     = 10'(yy);
    vde   = v;
    hsync = 1'b0;
    vsync = 1'b0;
    {base_red, base_green, base_blue} = base_of(xx, yy);
  endtask

  // Drive one pixel, let it cross both stages, then compare the output pixel and vde.
  task automatic px(input string tag, input int xx, input int yy, input logic v,
                    input logic [23:0] exp);
    drive(xx, yy, v);
    tick();
    tick();
    chk(tag, {8'h00, red, green, blue}, {8'h00, exp});
    chk({tag, "_vde"}, {31'd0, vde_o}, {31'd0, v});
  endtask

  logic [26:0] hist [0:11];
  logic [23:0] bv;

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_outline = 1'b0;
    cfg_x0 = '0; cfg_x1 = '0; cfg_y0 = '0; cfg_y1 = '0; cfg_color = '0; frame_start = 1'b0;
    x = 10'd3; y = 10'd3; vde = 1'b1; hsync = 1'b1; vsync = 1'b1;
    {base_red, base_green, base_blue} = 24'hABCDEF;
    tick(); tick(); tick();
    chk("reset_outputs", {5'd0, vde_o, hsync_o, vsync_o, red, green, blue}, 32'd0);
    rst = 1'b0;

    // Streaming ramp with toggling syncs: output must be the input from two edges earlier.
    for (int k = 0; k < 12; k++) begin
      bv = {8'(k * 7), 8'(255 - k), 8'(k + 3)};
      x = 10'(k + 200); y = 10'd300;
      vde = (k != 5); hsync = k[0]; vsync = k[1];
      {base_red, base_green, base_blue} = bv;
      hist[k] = {vde, hsync, vsync, (k != 5) ? bv : 24'h0};
      tick();
      if (k >= 1) begin
        chk($sformatf("stream_%0d", k - 1),
            {5'd0, vde_o, hsync_o, vsync_o, red, green, blue}, {5'd0, hist[k - 1]});
      end
    end

    // Filled box0, not visible until the swap.
    cfg(0, 1'b1, 1'b0, 0, 0, 119, 59, 24'h00FF00, 1'b0);
    px("pre_swap_base", 5, 5, 1'b1, base_of(5, 5));
    swap();
    px("fill_00", 0, 0, 1'b1, 24'h00FF00);
    px("fill_corner", 119, 59, 1'b1, 24'h00FF00);
    px("fill_x_out", 120, 59, 1'b1, base_of(120, 59));
    px("fill_y_out", 119, 60, 1'b1, base_of(119, 60));

    // Outline box1 with box0 disabled.
    cfg(0, 1'b0, 1'b0, 0, 0, 119, 59, 24'h00FF00, 1'b0);
    cfg(1, 1'b1, 1'b1, 10, 10, 20, 20, 24'hFF0000, 1'b0);
    swap();
    px("ol_left", 10, 15, 1'b1, 24'hFF0000);
    px("ol_corner", 20, 20, 1'b1, 24'hFF0000);
    px("ol_top", 15, 10, 1'b1, 24'hFF0000);
    px("ol_inside", 15, 15, 1'b1, base_of(15, 15));
    px("ol_outside", 9, 10, 1'b1, base_of(9, 10));

    // Overlap priority: box0 blue over box2 white and box1 outline.
    cfg(0, 1'b1, 1'b0, 0, 0, 50, 50, 24'h0000FF, 1'b0);
    cfg(2, 1'b1, 1'b0, 40, 40, 60, 60, 24'hFFFFFF, 1'b0);
    swap();
    px("prio_blue", 45, 45, 1'b1, 24'h0000FF);
    px("prio_white", 55, 55, 1'b1, 24'hFFFFFF);
    px("prio_over_ol", 15, 10, 1'b1, 24'h0000FF);

    // Write coinciding with frame_start is deferred one frame.
    cfg(3, 1'b1, 1'b0, 100, 100, 110, 110, 24'hFFFF00, 1'b1);
    px("defer_absent", 105, 105, 1'b1, base_of(105, 105));
    swap();
    px("defer_drawn", 105, 105, 1'b1, 24'hFFFF00);

    // Swap while a hit pixel is in stage 1 must keep its original colour.
    cfg(3, 1'b0, 1'b0, 100, 100, 110, 110, 24'h00FFFF, 1'b0);
    drive(105, 105, 1'b1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    chk("inflight_swap", {8'h00, red, green, blue}, 32'h00FFFF00);
    px("after_swap_off", 105, 105, 1'b1, base_of(105, 105));

    // Inverted x bounds never hit.
    cfg(2, 1'b1, 1'b0, 30, 200, 20, 210, 24'hFFFFFF, 1'b0);
    swap();
    px("inv_mid", 25, 205, 1'b1, base_of(25, 205));
    px("inv_x0", 30, 205, 1'b1, base_of(30, 205));
    px("inv_x1", 20, 205, 1'b1, base_of(20, 205));

    // Blanking inside an enabled box.
    px("vde_low", 45, 45, 1'b0, 24'h000000);

    // Mid-line reset with a hit pixel in flight.
    drive(45, 45, 1'b1);
    hsync = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    chk("midreset_out", {5'd0, vde_o, hsync_o, vsync_o, red, green, blue}, 32'd0);
    rst = 1'b0;
    px("post_reset_pass", 45, 45, 1'b1, base_of(45, 45));
    cfg(0, 1'b1, 1'b0, 0, 0, 50, 50, 24'h00FF00, 1'b0);
    px("post_reset_noswap", 45, 45, 1'b1, base_of(45, 45));
    swap();
    px("post_reset_swap", 45, 45, 1'b1, 24'h00FF00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
